// File: rtl/regfile_mp_pkg.sv
// Shared widths for the zerocpu register file. The module parameter defaults
// come from these values.
package regfile_mp_pkg;

    localparam int data_width = 64;
    localparam int regs_addr  = 5;
    localparam int regs_num   = 1 << regs_addr;

endpackage

// File: rtl/regfile_bypass_mux.sv
// Per-read-port data select: stored value, optionally overridden by a matching
// write in the same cycle (highest write port wins), forced to zero for x0/reset.
module regfile_bypass_mux
    import regfile_mp_pkg::*;
#(
    parameter int DATA_W   = data_width,
    parameter int ADDR_W   = regs_addr,
    parameter int NUM_WR   = 1,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                     flush_i,
    input  logic [ADDR_W-1:0]        rd_addr_i,
    input  logic [DATA_W-1:0]        reg_data_i,
    input  logic [NUM_WR-1:0]        wr_en_i,
    input  logic [NUM_WR*ADDR_W-1:0] wr_addr_i,
    input  logic [NUM_WR*DATA_W-1:0] wr_data_i,
    output logic [DATA_W-1:0]        rd_data_o
);

    logic is_zero;
    assign is_zero = (ZERO_REG != 0) && (rd_addr_i == '0);

    always_comb begin
        rd_data_o = reg_data_i;
        if (BYPASS != 0) begin
            // Ascending scan so the later port overrides the earlier one.
            for (int j = 0; j < NUM_WR; j++) begin
                if (wr_en_i[j] && (wr_addr_i[j*ADDR_W +: ADDR_W] == rd_addr_i)) begin
                    rd_data_o = wr_data_i[j*DATA_W +: DATA_W];
                end
            end
        end
        if (is_zero || flush_i) begin
            rd_data_o = '0;
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with busy scoreboard, optional write-to-read
// bypass, hardwired x0 and a one-cycle-delayed snapshot bus for difftest.
module regfile_mp
    import regfile_mp_pkg::*;
#(
    parameter int DATA_W   = data_width,
    parameter int ADDR_W   = regs_addr,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 1,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NUM_RD*ADDR_W-1:0]      rd_addr_i,
    output logic [NUM_RD*DATA_W-1:0]      rd_data_o,
    output logic [NUM_RD-1:0]             rd_busy_o,
    input  logic [NUM_WR-1:0]             wr_en_i,
    input  logic [NUM_WR*ADDR_W-1:0]      wr_addr_i,
    input  logic [NUM_WR*DATA_W-1:0]      wr_data_i,
    input  logic [NUM_WR-1:0]             wr_clr_i,
    input  logic                          iss_en_i,
    input  logic [ADDR_W-1:0]             iss_addr_i,
    output logic [(2**ADDR_W)*DATA_W-1:0] dbg_regs_o
);

    localparam int NREG = 2**ADDR_W;

    logic [DATA_W-1:0]      regs_q [NREG];
    logic [DATA_W-1:0]      regs_d [NREG];
    logic [NREG-1:0]        busy_q;
    logic [NREG-1:0]        busy_d;
    logic [NREG*DATA_W-1:0] dbg_q;
    logic [NREG*DATA_W-1:0] dbg_d;

    logic [NUM_WR-1:0] wr_ok;
    logic [NUM_WR-1:0] clr_ok;
    logic              iss_ok;

    // Writes, clears and issues aimed at a hardwired x0 are dropped here once.
    for (genvar gi = 0; gi < NUM_WR; gi++) begin : g_wr_qual
        assign wr_ok[gi]  = wr_en_i[gi]
                          && !((ZERO_REG != 0) && (wr_addr_i[gi*ADDR_W +: ADDR_W] == '0));
        assign clr_ok[gi] = wr_ok[gi] && wr_clr_i[gi];
    end

    assign iss_ok = iss_en_i && !((ZERO_REG != 0) && (iss_addr_i == '0));

    always_comb begin
        regs_d = regs_q;
        for (int j = 0; j < NUM_WR; j++) begin
            if (wr_ok[j]) begin
                regs_d[wr_addr_i[j*ADDR_W +: ADDR_W]] = wr_data_i[j*DATA_W +: DATA_W];
            end
        end
    end

    // Clear first, then set, so a new producer supersedes a retiring one.
    always_comb begin
        busy_d = busy_q;
        for (int j = 0; j < NUM_WR; j++) begin
            if (clr_ok[j]) begin
                busy_d[wr_addr_i[j*ADDR_W +: ADDR_W]] = 1'b0;
            end
        end
        if (iss_ok) begin
            busy_d[iss_addr_i] = 1'b1;
        end
    end

    for (genvar gi = 0; gi < NREG; gi++) begin : g_dbg
        assign dbg_d[gi*DATA_W +: DATA_W] = regs_q[gi];
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int k = 0; k < NREG; k++) begin
                regs_q[k] <= '0;
            end
            busy_q <= '0;
            dbg_q  <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
            dbg_q  <= dbg_d;
        end
    end

    assign dbg_regs_o = dbg_q;

    for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        logic              clr_hit;
        logic              iss_hit;
        logic              zero_hit;

        assign addr     = rd_addr_i[gi*ADDR_W +: ADDR_W];
        assign iss_hit  = iss_ok && (iss_addr_i == addr);
        assign zero_hit = (ZERO_REG != 0) && (addr == '0);

        always_comb begin
            clr_hit = 1'b0;
            for (int j = 0; j < NUM_WR; j++) begin
                if (clr_ok[j] && (wr_addr_i[j*ADDR_W +: ADDR_W] == addr)) begin
                    clr_hit = 1'b1;
                end
            end
        end

        assign rd_busy_o[gi] = !rst_i && busy_q[addr] && !zero_hit
                             && !((BYPASS != 0) && clr_hit && !iss_hit);

        regfile_bypass_mux #(
            .DATA_W   (DATA_W),
            .ADDR_W   (ADDR_W),
            .NUM_WR   (NUM_WR),
            .ZERO_REG (ZERO_REG),
            .BYPASS   (BYPASS)
        ) u_mux (
            .flush_i    (rst_i),
            .rd_addr_i  (addr),
            .reg_data_i (regs_q[addr]),
            .wr_en_i    (wr_en_i),
            .wr_addr_i  (wr_addr_i),
            .wr_data_i  (wr_data_i),
            .rd_data_o  (rd_data_o[gi*DATA_W +: DATA_W])
        );
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench: one bypassing and one non-bypassing dual-write instance share
// the same stimulus; each check is compared against hand-computed values.
module tb_regfile_mp;

    logic           clk;
    logic           rst;
    logic [9:0]     rd_addr;
    logic [1:0]     wr_en;
    logic [9:0]     wr_addr;
    logic [127:0]   wr_data;
    logic [1:0]     wr_clr;
    logic           iss_en;
    logic [4:0]     iss_addr;

    logic [127:0]   rd_data_b, rd_data_n;
    logic [1:0]     rd_busy_b, rd_busy_n;
    logic [2047:0]  dbg_b, dbg_n;

    int n_vec = 0;
    int n_bad = 0;

    localparam logic [63:0] SNAP = 64'hFFFF_0000_FFFF_0000;

    regfile_mp #(
        .DATA_W(64), .ADDR_W(5), .NUM_RD(2), .NUM_WR(2), .ZERO_REG(1), .BYPASS(1)
    ) u_byp (
        .clk_i(clk), .rst_i(rst),
        .rd_addr_i(rd_addr), .rd_data_o(rd_data_b), .rd_busy_o(rd_busy_b),
        .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data), .wr_clr_i(wr_clr),
        .iss_en_i(iss_en), .iss_addr_i(iss_addr), .dbg_regs_o(dbg_b)
    );

    regfile_mp #(
        .DATA_W(64), .ADDR_W(5), .NUM_RD(2), .NUM_WR(2), .ZERO_REG(1), .BYPASS(0)
    ) u_nob (
        .clk_i(clk), .rst_i(rst),
        .rd_addr_i(rd_addr), .rd_data_o(rd_data_n), .rd_busy_o(rd_busy_n),
        .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data), .wr_clr_i(wr_clr),
        .iss_en_i(iss_en), .iss_addr_i(iss_addr), .dbg_regs_o(dbg_n)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end else begin
            $display("ok   %s = %h", tag, got);
        end
    endtask

    function automatic logic [63:0] rdb(input int p);
        return rd_data_b[p*64 +: 64];
    endfunction

    function automatic logic [63:0] rdn(input int p);
        return rd_data_n[p*64 +: 64];
    endfunction

    task automatic idle();
        wr_en  = '0;
        wr_clr = '0;
        iss_en = 1'b0;
    endtask

    task automatic wport(input int p, input logic [4:0] a, input logic [63:0] d, input logic clr);
        wr_en[p]             = 1'b1;
        wr_addr[p*5 +: 5]    = a;
        wr_data[p*64 +: 64]  = d;
        wr_clr[p]            = clr;
    endtask

    task automatic rport(input int p, input logic [4:0] a);
        rd_addr[p*5 +: 5] = a;
    endtask

    task automatic issue(input logic [4:0] a);
        iss_en   = 1'b1;
        iss_addr = a;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        rd_addr = '0; wr_addr = '0; wr_data = '0; iss_addr = '0;
        idle();

        // Write offered during reset must be discarded, outputs held at zero.
        wport(0, 5'd5, 64'hDEAD, 1'b0);
        issue(5'd5);
        rport(0, 5'd5);
        #2;
        chk("rst_rd_byp", rdb(0), 64'h0);
        chk("rst_busy_byp", {63'd0, rd_busy_b[0]}, 64'h0);
        tick();
        rst = 1'b0;
        idle();
        #1;
        chk("postrst_x5_byp", rdb(0), 64'h0);
        chk("postrst_x5_nob", rdn(0), 64'h0);
        chk("postrst_busy_x5", {63'd0, rd_busy_n[0]}, 64'h0);
        chk("postrst_dbg", {63'd0, |dbg_n}, 64'h0);

        // Same-cycle bypass vs next-cycle visibility.
        tick();
        wport(0, 5'd7, 64'hA5A5, 1'b0);
        rport(0, 5'd7);
        #1;
        chk("byp_x7_same", rdb(0), 64'hA5A5);
        chk("nob_x7_same", rdn(0), 64'h0);
        tick();
        idle();
        #1;
        chk("byp_x7_next", rdb(0), 64'hA5A5);
        chk("nob_x7_next", rdn(0), 64'hA5A5);

        // Hardwired x0 ignores writes and issues.
        wport(0, 5'd0, 64'h1234, 1'b0);
        issue(5'd0);
        rport(0, 5'd0);
        #1;
        chk("x0_rd_byp_same", rdb(0), 64'h0);
        chk("x0_busy_byp_same", {63'd0, rd_busy_b[0]}, 64'h0);
        tick();
        idle();
        #1;
        chk("x0_rd_nob_next", rdn(0), 64'h0);
        chk("x0_busy_nob_next", {63'd0, rd_busy_n[0]}, 64'h0);

        // Dual-port collision: port 1 wins.
        wport(0, 5'd3, 64'h1, 1'b0);
        wport(1, 5'd3, 64'h2, 1'b0);
        rport(1, 5'd3);
        #1;
        chk("coll_byp_same", rdb(1), 64'h2);
        chk("coll_nob_same", rdn(1), 64'h0);
        tick();
        idle();
        #1;
        chk("coll_byp_next", rdb(1), 64'h2);
        chk("coll_nob_next", rdn(1), 64'h2);

        // Scoreboard: issue x9 in cycle 0, clearing write in cycle 3.
        issue(5'd9);
        rport(0, 5'd9);
        #1;
        chk("sb_c0_byp", {63'd0, rd_busy_b[0]}, 64'h0);
        tick();
        idle();
        #1;
        chk("sb_c1_byp", {63'd0, rd_busy_b[0]}, 64'h1);
        chk("sb_c1_nob", {63'd0, rd_busy_n[0]}, 64'h1);
        tick();
        #1;
        chk("sb_c2_nob", {63'd0, rd_busy_n[0]}, 64'h1);
        tick();
        wport(0, 5'd9, 64'h99, 1'b1);
        #1;
        chk("sb_c3_byp", {63'd0, rd_busy_b[0]}, 64'h0);
        chk("sb_c3_nob", {63'd0, rd_busy_n[0]}, 64'h1);
        chk("sb_c3_data_byp", rdb(0), 64'h99);
        tick();
        idle();
        #1;
        chk("sb_c4_byp", {63'd0, rd_busy_b[0]}, 64'h0);
        chk("sb_c4_nob", {63'd0, rd_busy_n[0]}, 64'h0);
        chk("sb_c4_data_nob", rdn(0), 64'h99);

        // Re-issue, then clear and issue the same register together: stays busy.
        issue(5'd9);
        tick();
        idle();
        #1;
        chk("sb_reiss_byp", {63'd0, rd_busy_b[0]}, 64'h1);
        wport(0, 5'd9, 64'h77, 1'b1);
        issue(5'd9);
        #1;
        chk("sb_setclr_same_byp", {63'd0, rd_busy_b[0]}, 64'h1);
        chk("sb_setclr_same_nob", {63'd0, rd_busy_n[0]}, 64'h1);
        tick();
        idle();
        #1;
        chk("sb_setclr_next_byp", {63'd0, rd_busy_b[0]}, 64'h1);
        chk("sb_setclr_next_nob", {63'd0, rd_busy_n[0]}, 64'h1);

        // Snapshot trails the architectural state by one edge.
        wport(0, 5'd31, SNAP, 1'b0);
        rport(1, 5'd31);
        tick();
        idle();
        #1;
        chk("snap_rd_nob", rdn(1), SNAP);
        chk("snap_dbg_n", dbg_n[31*64 +: 64], 64'h0);
        tick();
        #1;
        chk("snap_dbg_n1_nob", dbg_n[31*64 +: 64], SNAP);
        chk("snap_dbg_n1_byp", dbg_b[31*64 +: 64], SNAP);
        chk("snap_dbg_x7", dbg_b[7*64 +: 64], 64'hA5A5);

        // Asynchronous reset mid-cycle wipes data, busy and snapshot at once.
        wport(0, 5'd5, 64'hDEAD, 1'b0);
        tick();
        idle();
        rport(0, 5'd5);
        rport(1, 5'd9);
        #1;
        chk("pre_arst_x5", rdn(0), 64'hDEAD);
        chk("pre_arst_busy9", {63'd0, rd_busy_n[1]}, 64'h1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_x5_byp", rdb(0), 64'h0);
        chk("arst_x5_nob", rdn(0), 64'h0);
        chk("arst_busy9_nob", {63'd0, rd_busy_n[1]}, 64'h0);
        chk("arst_dbg_n", {63'd0, |dbg_n}, 64'h0);
        chk("arst_dbg_b", {63'd0, |dbg_b}, 64'h0);
        tick();
        rst = 1'b0;
        #1;
        chk("postarst_x5", rdb(0), 64'h0);
        chk("postarst_busy9", {63'd0, rd_busy_b[1]}, 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
